z_sdpram_rd_arb: RTL

Read-port arbiter for `z_sdpram`. It shares the single RAM read port among `NUM_REQ` requesters using a valid/ready request handshake. The block tracks each issued read through the RAM's fixed read latency and returns the data to the requester that issued it. It sits between buffer consumers (e.g. systolic-array feeders) and one `z_sdpram` instance; the RAM write port is not touched.

---
 rtl/z_sdpram_rd_arb.sv | 110 +++++++++++
 1 files changed

// File: rtl/z_sdpram_rd_arb.sv
// Read-port arbiter sharing one z_sdpram read port among NUM_REQ requesters.
// Define Z_SDPRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module z_sdpram_rd_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          ram_ena_r,
    output logic [ADDR_WIDTH-1:0]         ram_addr_r,
    input  logic [DATA_WIDTH-1:0]         ram_dout,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant;
    logic               grant_any;

`ifdef Z_SDPRAM_ARB_RR_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;

    // Descending scan so the candidate at the pointer (k = 0) is written last and wins.
    always_comb begin
        int cand;
        grant = '0;
        gidx  = '0;
        cand  = 0;
        if (!rst) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = int'(ptr) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (req_valid[IDX_W'(cand)]) begin
                    grant              = '0;
                    grant[IDX_W'(cand)] = 1'b1;
                    gidx               = IDX_W'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end
`else
    always_comb begin
        grant = '0;
        if (!rst) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[IDX_W'(k)]) begin
                    grant              = '0;
                    grant[IDX_W'(k)]   = 1'b1;
                end
            end
        end
    end
`endif

    assign grant_any = |grant;
    assign req_ready = grant;

    // One-hot AND-OR address mux; zero when nothing is granted.
    always_comb begin
        ram_addr_r = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) ram_addr_r = ram_addr_r | req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Tag pipeline: stage 0 captures the grant, stage LATENCY-1 lines up with ram_dout.
    logic               vld_p [LATENCY];
    logic [NUM_REQ-1:0] id_p  [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= grant_any;
            for (int k = 1; k < LATENCY; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        id_p[0] <= grant;
        for (int k = 1; k < LATENCY; k++) id_p[k] <= id_p[k-1];
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LATENCY; k++) busy = busy | vld_p[k];
    end

    // The RAM pipeline keeps stepping while reads are in flight so latency stays fixed.
    assign ram_ena_r = !rst && (grant_any || busy);
    assign rsp_valid = vld_p[LATENCY-1] ? id_p[LATENCY-1] : '0;
    assign rsp_data  = ram_dout;

endmodule
